// File: rtl/reset_sequencer.sv
// reset_sequencer: ordered release of N_DOM reset domains after PLL lock.
// Handles lock loss, software restart and per-domain ack timeout.
module reset_sequencer #(
   parameter int N_DOM       = 3,
   parameter int HOLD_CYC    = 4,
   parameter int LOCK_CYC    = 8,
   parameter int GAP_CYC     = 2,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pll_locked,
   input  logic             sw_rst_req,
   input  logic [N_DOM-1:0] dom_ack,
   output logic [N_DOM-1:0] dom_rst_n,
   output logic             seq_done,
   output logic             fault,
   output logic [2:0]       state
);

   typedef enum logic [2:0] {
      S_HOLD      = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_RELEASE   = 3'd2,
      S_GAP       = 3'd3,
      S_RUN       = 3'd4,
      S_FAULT     = 3'd5
   } state_t;

   localparam int MAX_HL = (HOLD_CYC > LOCK_CYC) ? HOLD_CYC : LOCK_CYC;
   localparam int MAX_GT = (GAP_CYC > TIMEOUT_CYC) ? GAP_CYC : TIMEOUT_CYC;
   localparam int MAX_C  = (MAX_HL > MAX_GT) ? MAX_HL : MAX_GT;
   localparam int CNT_W  = $clog2(MAX_C + 1);
   localparam int IDX_W  = (N_DOM > 1) ? $clog2(N_DOM) : 1;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
   localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DOM - 1);

   logic             lock_m;
   logic             lock_s;
   logic [N_DOM-1:0] ack_m;
   logic [N_DOM-1:0] ack_s;

   state_t           st;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] idx_nx;
   logic             lock_lost;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lock_m <= 1'b0;
         lock_s <= 1'b0;
         ack_m  <= '0;
         ack_s  <= '0;
      end else begin
         lock_m <= pll_locked;
         lock_s <= lock_m;
         ack_m  <= dom_ack;
         ack_s  <= ack_m;
      end
   end

   // one shared counter; each state restarts it on entry
   assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;
   assign idx_nx  = idx + 1'b1;

   assign lock_lost = !lock_s &&
                      (st == S_RELEASE || st == S_GAP || st == S_RUN);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st        <= S_HOLD;
         cnt       <= '0;
         idx       <= '0;
         dom_rst_n <= '0;
         seq_done  <= 1'b0;
         fault     <= 1'b0;
      end else if (sw_rst_req && st != S_HOLD) begin
         st        <= S_HOLD;
         cnt       <= '0;
         idx       <= '0;
         dom_rst_n <= '0;
         seq_done  <= 1'b0;
         fault     <= 1'b0;
      end else if (lock_lost) begin
         st        <= S_WAIT_LOCK;
         cnt       <= '0;
         idx       <= '0;
         dom_rst_n <= '0;
         seq_done  <= 1'b0;
      end else begin
         unique case (st)
            S_HOLD: begin
               dom_rst_n <= '0;
               seq_done  <= 1'b0;
               fault     <= 1'b0;
               if (cnt == HOLD_LAST) begin
                  st  <= S_WAIT_LOCK;
                  cnt <= '0;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            S_WAIT_LOCK: begin
               if (!lock_s) begin
                  cnt <= '0;
               end else if (cnt == LOCK_LAST) begin
                  st           <= S_RELEASE;
                  cnt          <= '0;
                  idx          <= '0;
                  dom_rst_n[0] <= 1'b1;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            S_RELEASE: begin
               // timeout outranks an ack landing on the last allowed cycle
               if (cnt == TMO_LAST) begin
                  st        <= S_FAULT;
                  cnt       <= '0;
                  dom_rst_n <= '0;
                  seq_done  <= 1'b0;
                  fault     <= 1'b1;
               end else if (ack_s[idx]) begin
                  cnt <= '0;
                  if (idx == IDX_LAST) begin
                     st       <= S_RUN;
                     seq_done <= 1'b1;
                  end else begin
                     st <= S_GAP;
                  end
               end else begin
                  cnt <= cnt_inc;
               end
            end
            S_GAP: begin
               if (cnt == GAP_LAST) begin
                  st                <= S_RELEASE;
                  cnt               <= '0;
                  idx               <= idx_nx;
                  dom_rst_n[idx_nx] <= 1'b1;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            S_RUN: begin
               seq_done <= 1'b1;
            end
            S_FAULT: begin
               dom_rst_n <= '0;
               seq_done  <= 1'b0;
               fault     <= 1'b1;
            end
            default: begin
               st        <= S_HOLD;
               cnt       <= '0;
               idx       <= '0;
               dom_rst_n <= '0;
               seq_done  <= 1'b0;
               fault     <= 1'b0;
            end
         endcase
      end
   end

   assign state = st;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed scenarios with an output-change scoreboard.
// Acks loop back from dom_rst_n through a 3-cycle delay.
module tb_reset_sequencer;

   localparam int N = 3;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         pll_locked = 1'b1;
   logic         sw_rst_req = 1'b0;
   logic [N-1:0] dom_ack;
   logic [N-1:0] dom_rst_n;
   logic         seq_done;
   logic         fault;
   logic [2:0]   state;

   logic [N-1:0] d1 = '0;
   logic [N-1:0] d2 = '0;
   logic [N-1:0] d3 = '0;
   logic [N-1:0] ack_mask = '1;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      d1 <= dom_rst_n;
      d2 <= d1;
      d3 <= d2;
   end

   assign dom_ack = d3 & ack_mask;

   reset_sequencer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pll_locked (pll_locked),
      .sw_rst_req (sw_rst_req),
      .dom_ack    (dom_ack),
      .dom_rst_n  (dom_rst_n),
      .seq_done   (seq_done),
      .fault      (fault),
      .state      (state)
   );

   typedef struct {
      int           cyc;
      logic [N-1:0] rst;
      logic         done;
      logic         flt;
   } ev_t;

   ev_t          sb[$];
   int           cyc = 0;
   int           n_cmp = 0;
   int           n_bad = 0;
   bit           mon_on = 1'b0;
   logic [N+1:0] prev;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s obs=%0h exp=%0h cyc=%0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic expect_ev(input int c, input logic [N-1:0] r,
                            input logic d, input logic f);
      ev_t e;
      e.cyc  = c;
      e.rst  = r;
      e.done = d;
      e.flt  = f;
      sb.push_back(e);
   endtask

   task automatic push_seq(input int r);
      expect_ev(r,      3'b001, 1'b0, 1'b0);
      expect_ev(r + 8,  3'b011, 1'b0, 1'b0);
      expect_ev(r + 16, 3'b111, 1'b0, 1'b0);
      expect_ev(r + 22, 3'b111, 1'b1, 1'b0);
   endtask

   task automatic tick();
      logic [N+1:0] cur;
      ev_t          e;
      @(posedge clk);
      #1;
      cyc++;
      cur = {dom_rst_n, seq_done, fault};
      if (mon_on && cur !== prev) begin
         n_cmp++;
         assert (sb.size() > 0) else begin
            n_bad++;
            $error("FAIL unexpected_event obs=%0h exp=none cyc=%0d",
                   cur, cyc);
         end
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("ev_cycle", cyc, e.cyc);
            chk("ev_value", cur, {e.rst, e.done, e.flt});
         end
      end
      prev = cur;
   endtask

   task automatic run_to(input int t);
      while (cyc < t) tick();
   endtask

   task automatic sw_pulse();
      expect_ev(cyc + 1, 3'b000, 1'b0, 1'b0);
      sw_rst_req = 1'b1;
      tick();
      sw_rst_req = 1'b0;
   endtask

   initial begin
      #100000;
      $error("FAIL watchdog obs=running exp=finished");
      $fatal(1);
   end

   initial begin
      int h;
      int s;
      int a;
      int b;

      repeat (4) tick();
      chk("rst_state", state, 3'd0);
      chk("rst_dom", dom_rst_n, 3'b000);
      chk("rst_done", seq_done, 1'b0);
      chk("rst_fault", fault, 1'b0);
      prev   = {dom_rst_n, seq_done, fault};
      mon_on = 1'b1;

      // normal bring-up from rst_n
      h = cyc;
      rst_n = 1'b1;
      push_seq(h + 12);
      run_to(h + 3);
      chk("hold_last", state, 3'd0);
      run_to(h + 4);
      chk("wait_entry", state, 3'd1);
      run_to(h + 14);
      chk("release0", state, 3'd2);
      run_to(h + 19);
      chk("gap0", state, 3'd3);
      run_to(h + 34);
      chk("run_state", state, 3'd4);
      chk("run_done", seq_done, 1'b1);
      run_to(h + 40);
      chk("sb_empty_bringup", sb.size(), 0);

      // lock loss in RUN, then relock
      a = cyc;
      pll_locked = 1'b0;
      expect_ev(a + 3, 3'b000, 1'b0, 1'b0);
      run_to(a + 2);
      chk("lockloss_still_run", state, 3'd4);
      run_to(a + 3);
      chk("lockloss_wait", state, 3'd1);
      run_to(a + 5);
      b = cyc;
      pll_locked = 1'b1;
      push_seq(b + 10);
      run_to(b + 9);
      chk("relock_wait", state, 3'd1);
      run_to(b + 10);
      chk("relock_release", state, 3'd2);
      run_to(b + 40);
      chk("sb_empty_relock", sb.size(), 0);

      // sw restart from RUN, lock glitch at count 5
      sw_pulse();
      h = cyc;
      chk("sw_hold", state, 3'd0);
      push_seq(h + 18);
      run_to(h + 7);
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      run_to(h + 17);
      chk("glitch_no_release", dom_rst_n, 3'b000);
      run_to(h + 50);
      chk("sb_empty_glitch", sb.size(), 0);

      // domain 1 never acks -> fault
      sw_pulse();
      h = cyc;
      ack_mask = 3'b101;
      expect_ev(h + 12, 3'b001, 1'b0, 1'b0);
      expect_ev(h + 20, 3'b011, 1'b0, 1'b0);
      expect_ev(h + 36, 3'b000, 1'b0, 1'b1);
      run_to(h + 35);
      chk("tmo_release1", state, 3'd2);
      run_to(h + 36);
      chk("fault_state", state, 3'd5);
      chk("fault_flag", fault, 1'b1);
      run_to(h + 45);
      chk("fault_sticky", state, 3'd5);
      ack_mask = '1;
      sw_pulse();
      s = cyc;
      chk("fault_clr_state", state, 3'd0);
      chk("fault_clr_flag", fault, 1'b0);

      // sw_rst_req while in HOLD must not extend HOLD
      run_to(s + 1);
      sw_rst_req = 1'b1;
      tick();
      sw_rst_req = 1'b0;
      push_seq(s + 12);
      run_to(s + 3);
      chk("hold_ignore_sw", state, 3'd0);
      run_to(s + 4);
      chk("hold_not_extended", state, 3'd1);
      run_to(s + 40);
      chk("sb_empty_fault", sb.size(), 0);

      // sw_rst_req and lock drop together in GAP
      sw_pulse();
      h = cyc;
      expect_ev(h + 12, 3'b001, 1'b0, 1'b0);
      run_to(h + 18);
      chk("gap_before_race", state, 3'd3);
      sw_rst_req = 1'b1;
      pll_locked = 1'b0;
      expect_ev(h + 19, 3'b000, 1'b0, 1'b0);
      tick();
      sw_rst_req = 1'b0;
      s = cyc;
      chk("race_hold", state, 3'd0);
      run_to(s + 3);
      chk("race_hold_last", state, 3'd0);
      run_to(s + 4);
      chk("race_wait", state, 3'd1);
      run_to(s + 6);
      pll_locked = 1'b1;
      push_seq(s + 16);
      run_to(s + 40);
      chk("sb_empty_race", sb.size(), 0);

      // rst_n pulse during RELEASE(2)
      sw_pulse();
      s = cyc;
      expect_ev(s + 12, 3'b001, 1'b0, 1'b0);
      expect_ev(s + 20, 3'b011, 1'b0, 1'b0);
      expect_ev(s + 28, 3'b111, 1'b0, 1'b0);
      run_to(s + 29);
      chk("release2", state, 3'd2);
      rst_n = 1'b0;
      expect_ev(s + 30, 3'b000, 1'b0, 1'b0);
      tick();
      chk("midrst_state", state, 3'd0);
      chk("midrst_dom", dom_rst_n, 3'b000);
      chk("midrst_done", seq_done, 1'b0);
      chk("midrst_fault", fault, 1'b0);
      tick();
      h = cyc;
      rst_n = 1'b1;
      push_seq(h + 12);
      run_to(h + 40);
      chk("final_run", state, 3'd4);
      chk("sb_empty_final", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter: N_DOM, default 3, number of sequenced reset domains (1..8).
REQ-002 Parameter: HOLD_CYC, default 4, minimum cycles all domain resets stay asserted on any (re)entry to HOLD.
REQ-003 Parameter: LOCK_CYC, default 8, consecutive synchronized-lock cycles required before the first release.
REQ-004 Parameter: GAP_CYC, default 2, idle cycles between a domain's ack and the next domain's release.
REQ-005 Parameter: TIMEOUT_CYC, default 16, maximum cycles to wait for a domain ack.
REQ-006 Port: clk  in  1  sequencer clock.
REQ-007 Port: rst_n  in  1  reset, synchronous, active-low, on clk.
REQ-008 Port: pll_locked  in  1  asynchronous lock indication.
REQ-009 Port: sw_rst_req  in  1  synchronous request to restart the full sequence.
REQ-010 Port: dom_ack  in  N_DOM  asynchronous per-domain indication that the domain's local reset has deasserted.
REQ-011 Port: dom_rst_n  out  N_DOM  per-domain active-low reset request; each domain re-synchronizes it locally.
REQ-012 Port: seq_done  out  1  all domains released and acknowledged.
REQ-013 Port: fault  out  1  ack timeout occurred.
REQ-014 Port: state  out  3  current FSM state encoding, for debug.

Function
REQ-015 pll_locked and each dom_ack bit SHALL pass through a 2-flop synchronizer (lock_s, ack_s) before use; the synchronizer flops reset to 0.
REQ-016 FSM states SHALL be HOLD=0, WAIT_LOCK=1, RELEASE=2, GAP=3, RUN=4, FAULT=5.
REQ-017 HOLD: all dom_rst_n=0; remains in HOLD for exactly HOLD_CYC cycles, then goes to WAIT_LOCK.
REQ-018 WAIT_LOCK: a counter increments each cycle lock_s=1 and clears when lock_s=0; on reaching LOCK_CYC, go to RELEASE with idx=0.
REQ-019 dom_rst_n[idx] SHALL be registered high in the first cycle of RELEASE(idx); released bits stay high until a return to HOLD, WAIT_LOCK or FAULT.
REQ-020 RELEASE: on ack_s[idx]=1, go to RUN if idx=N_DOM-1, else to GAP.
REQ-021 RELEASE: if TIMEOUT_CYC cycles elapse without ack_s[idx], go to FAULT.
REQ-022 GAP: lasts exactly GAP_CYC cycles, then increments idx and enters RELEASE.
REQ-023 RUN: seq_done=1, all dom_rst_n=1; the FSM remains in RUN until a REQ-025 or REQ-026 event.
REQ-024 FAULT: all dom_rst_n=0, fault=1, seq_done=0; the FSM stays in FAULT until sw_rst_req or rst_n.
REQ-025 A lock_s=0 observation in RELEASE, GAP or RUN SHALL, in the next cycle, drive all dom_rst_n=0 and seq_done=0, clear idx, and go to WAIT_LOCK.
REQ-026 sw_rst_req=1 in any state except HOLD SHALL, in the next cycle, drive all dom_rst_n=0, seq_done=0 and fault=0, and go to HOLD with a fresh HOLD_CYC count.
REQ-027 sw_rst_req asserted while in HOLD SHALL be ignored and SHALL NOT extend HOLD.
REQ-028 Event priority SHALL be rst_n > sw_rst_req > lock loss > timeout > ack > counter expiry.
REQ-029 dom_rst_n bits SHALL be released strictly in index order, with at most one bit changing 0->1 per cycle.
REQ-030 All outputs SHALL be driven directly from flops.
REQ-031 Counters SHALL saturate and never wrap.

Reset
REQ-032 While rst_n=0: state=HOLD, dom_rst_n=0, seq_done=0, fault=0, idx=0, all counters 0, synchronizer flops 0.
REQ-033 After rst_n rises, the FSM SHALL spend HOLD_CYC cycles in HOLD.
REQ-034 rst_n=0 mid-sequence SHALL take effect at the next clk edge, regardless of state.

Verification (defaults, pll_locked=1 throughout unless stated)
REQ-035 rst_n released, dom_ack tied to dom_rst_n with 3-cycle delay -> dom_rst_n[0] rises at cycle 12 after rst_n release; bits rise in order 0,1,2; seq_done=1 after ack of bit 2.
REQ-036 pll_locked toggles low for 1 cycle at count 5 of WAIT_LOCK -> the lock counter restarts, and release is delayed by the glitch plus 8 further stable cycles.
REQ-037 dom_ack[1] held 0 -> 16 cycles after dom_rst_n[1] rises, fault=1, all dom_rst_n=0, state=5; sw_rst_req pulse -> fault=0, state=HOLD, full sequence restarts.
REQ-038 pll_locked dropped in RUN -> within 3 cycles all dom_rst_n=0, seq_done=0, state=WAIT_LOCK; on relock, the sequence replays from domain 0.
REQ-039 sw_rst_req and pll_locked fall in the same cycle during GAP -> state=HOLD (sw_rst_req wins), with HOLD lasting 4 cycles.
REQ-040 rst_n pulsed low during RELEASE(2) -> all outputs return to reset values at the next edge, then restart per REQ-035.
